// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard and memory-freeze controller.
// Produces PC/IF-ID freeze, ID/EX bubble, branch flushes and a global
// freeze for multi-cycle data memory accesses, with saturating event counters.
// Optional build macro PIPE_HAZARD_FORWARDING_EN: when defined, only load-use
// dependencies on the EX instruction stall (a forwarding network covers the
// rest); when undefined, any EX or MEM writeback dependency stalls.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT_CYCLES = 5,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       i_id_src1,
  input  logic [3:0]       i_id_src2,
  input  logic             i_id_two_src,
  input  logic             i_ex_wb_en,
  input  logic [3:0]       i_ex_dest,
  input  logic             i_ex_mem_rd,
  input  logic             i_mem_wb_en,
  input  logic [3:0]       i_mem_dest,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  output logic             o_pc_freeze,
  output logic             o_if_id_freeze,
  output logic             o_id_ex_bubble,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_all_freeze,
  output logic             o_mem_done,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // The IDLE cycle that sees the request is itself frozen, so the counter
  // starts one short of the total freeze length.
  localparam logic [3:0]       LP_WAIT_LOAD = 4'(MEM_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_nextState;
  logic [3:0]       r_wcnt;
  logic [3:0]       w_nextWcnt;
  logic             w_allFreeze;
  logic             w_memDone;
  logic             w_exHit;
  logic             w_hazard;
  logic             w_flush;
  logic             w_stall;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  // A source register matches the EX destination; id_src2 only counts when read.
  assign w_exHit = i_ex_wb_en &&
                   ((i_id_src1 == i_ex_dest) ||
                    (i_id_two_src && (i_id_src2 == i_ex_dest)));

`ifdef PIPE_HAZARD_FORWARDING_EN
  // MEM-stage results are forwarded, so those inputs do not affect stalling.
  logic w_unusedMemInputs;
  assign w_unusedMemInputs = i_mem_wb_en ^ (^i_mem_dest);
  assign w_hazard = w_exHit && i_ex_mem_rd;
`else
  // Without forwarding every pending writeback to a live source stalls,
  // so whether the EX instruction is a load is irrelevant.
  logic w_memHit;
  logic w_unusedLoadFlag;
  assign w_unusedLoadFlag = i_ex_mem_rd;
  assign w_memHit = i_mem_wb_en &&
                    ((i_id_src1 == i_mem_dest) ||
                     (i_id_two_src && (i_id_src2 == i_mem_dest)));
  assign w_hazard = w_exHit || w_memHit;
`endif

  // Memory-wait state register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_wcnt  <= w_nextWcnt;
    end
  end

  // Memory-wait next state: freeze on the request and while the counter runs,
  // release for exactly one cycle when it reaches zero.
  always_comb begin
    w_nextState = r_state;
    w_nextWcnt  = r_wcnt;
    w_allFreeze = 1'b0;
    w_memDone   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mem_req) begin
          w_allFreeze = 1'b1;
          w_nextState = MEM_WAIT;
          w_nextWcnt  = LP_WAIT_LOAD;
        end
      end
      MEM_WAIT: begin
        if (r_wcnt != 4'd0) begin
          w_allFreeze = 1'b1;
          w_nextWcnt  = r_wcnt - 4'd1;
        end else begin
          w_memDone   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextWcnt  = 4'd0;
      end
    endcase
  end

  // Output priority: global freeze, then branch flush, then hazard stall;
  // everything is forced low while reset is held.
  always_comb begin
    w_flush        = 1'b0;
    w_stall        = 1'b0;
    o_all_freeze   = 1'b0;
    o_mem_done     = 1'b0;
    if (!rst) begin
      o_all_freeze = w_allFreeze;
      o_mem_done   = w_memDone;
      if (!w_allFreeze) begin
        w_flush = i_branch_taken;
        w_stall = !i_branch_taken && w_hazard;
      end
    end
    o_pc_freeze    = w_stall;
    o_if_id_freeze = w_stall;
    o_id_ex_bubble = w_stall;
    o_if_id_flush  = w_flush;
    o_id_ex_flush  = w_flush;
  end

  // Saturating event counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != LP_CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + LP_CNT_ONE;
      end
      if (w_flush && (r_flushCnt != LP_CNT_MAX)) begin
        r_flushCnt <= r_flushCnt + LP_CNT_ONE;
      end
    end
  end

  assign o_stall_cnt = r_stallCnt;
  assign o_flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl.
// Two instances share stimulus: one default-sized, one with 4-bit counters
// to exercise saturation. Expectations honour PIPE_HAZARD_FORWARDING_EN.
module tb_pipe_hazard_ctrl;

  localparam int MW = 5;

  typedef struct {
    logic [3:0] src1;
    logic [3:0] src2;
    logic       two;
    logic       exWb;
    logic [3:0] exDest;
    logic       exRd;
    logic       memWb;
    logic [3:0] memDest;
    logic       branch;
    logic       memReq;
  } stimT;

  typedef struct {
    logic pcFreeze;
    logic ifIdFreeze;
    logic bubble;
    logic ifIdFlush;
    logic idExFlush;
    logic allFreeze;
    logic memDone;
    int   stallCnt;
    int   flushCnt;
    int   stallCnt4;
    int   flushCnt4;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  idSrc1, idSrc2, exDest, memDest;
  logic        idTwoSrc, exWbEn, exMemRd, memWbEn, branchTaken, memReq;
  logic        pcFreeze, ifIdFreeze, idExBubble, ifIdFlush, idExFlush, allFreeze, memDone;
  logic [15:0] stallCnt, flushCnt;
  logic        pcFreeze4, ifIdFreeze4, idExBubble4, ifIdFlush4, idExFlush4, allFreeze4, memDone4;
  logic [3:0]  stallCnt4, flushCnt4;

  int  assertCount = 0;
  int  failCount   = 0;
  expT expQ[$];

  // Reference model state: position within the current access (0 = idle,
  // 1..MW = frozen cycles, MW+1 = release) and the expected counter values.
  int modelPhase  = 0;
  int modelStall  = 0;
  int modelFlush  = 0;
  int modelStall4 = 0;
  int modelFlush4 = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(MW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc),
    .i_ex_wb_en(exWbEn), .i_ex_dest(exDest), .i_ex_mem_rd(exMemRd),
    .i_mem_wb_en(memWbEn), .i_mem_dest(memDest),
    .i_branch_taken(branchTaken), .i_mem_req(memReq),
    .o_pc_freeze(pcFreeze), .o_if_id_freeze(ifIdFreeze), .o_id_ex_bubble(idExBubble),
    .o_if_id_flush(ifIdFlush), .o_id_ex_flush(idExFlush),
    .o_all_freeze(allFreeze), .o_mem_done(memDone),
    .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
  );

  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(MW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .i_id_src1(idSrc1), .i_id_src2(idSrc2), .i_id_two_src(idTwoSrc),
    .i_ex_wb_en(exWbEn), .i_ex_dest(exDest), .i_ex_mem_rd(exMemRd),
    .i_mem_wb_en(memWbEn), .i_mem_dest(memDest),
    .i_branch_taken(branchTaken), .i_mem_req(memReq),
    .o_pc_freeze(pcFreeze4), .o_if_id_freeze(ifIdFreeze4), .o_id_ex_bubble(idExBubble4),
    .o_if_id_flush(ifIdFlush4), .o_id_ex_flush(idExFlush4),
    .o_all_freeze(allFreeze4), .o_mem_done(memDone4),
    .o_stall_cnt(stallCnt4), .o_flush_cnt(flushCnt4)
  );

  function automatic stimT mk(int s1, int s2, bit two, bit exWb, int exD, bit exRd,
                              bit memWb, int memD, bit br, bit req);
    stimT s;
    s.src1 = 4'(s1);   s.src2 = 4'(s2);   s.two = two;
    s.exWb = exWb;     s.exDest = 4'(exD); s.exRd = exRd;
    s.memWb = memWb;   s.memDest = 4'(memD);
    s.branch = br;     s.memReq = req;
    return s;
  endfunction

  function automatic expT zeroExp();
    expT e;
    e.pcFreeze = 0; e.ifIdFreeze = 0; e.bubble = 0;
    e.ifIdFlush = 0; e.idExFlush = 0; e.allFreeze = 0; e.memDone = 0;
    e.stallCnt = 0; e.flushCnt = 0; e.stallCnt4 = 0; e.flushCnt4 = 0;
    return e;
  endfunction

  function automatic int curPhase(stimT s);
    if (modelPhase == 0) return s.memReq ? 1 : 0;
    return modelPhase;
  endfunction

  function automatic expT predict(stimT s);
    expT  e;
    int   p;
    logic frz, exHit, memHit, hz, st;
    p      = curPhase(s);
    frz    = (p >= 1) && (p <= MW);
    exHit  = s.exWb  && ((s.src1 == s.exDest)  || (s.two && s.src2 == s.exDest));
    memHit = s.memWb && ((s.src1 == s.memDest) || (s.two && s.src2 == s.memDest));
`ifdef PIPE_HAZARD_FORWARDING_EN
    hz = exHit && s.exRd;
`else
    hz = exHit || memHit;
`endif
    st = hz && !frz && !s.branch;
    e.allFreeze  = frz;
    e.memDone    = (p == MW + 1);
    e.pcFreeze   = st;
    e.ifIdFreeze = st;
    e.bubble     = st;
    e.ifIdFlush  = s.branch && !frz;
    e.idExFlush  = s.branch && !frz;
    e.stallCnt   = modelStall;
    e.flushCnt   = modelFlush;
    e.stallCnt4  = modelStall4;
    e.flushCnt4  = modelFlush4;
    return e;
  endfunction

  task automatic modelAdvance(stimT s, expT e);
    int p;
    p = curPhase(s);
    if (p == 0 || p == MW + 1) modelPhase = 0;
    else                       modelPhase = p + 1;
    if (e.pcFreeze) begin
      if (modelStall  < 65535) modelStall++;
      if (modelStall4 < 15)    modelStall4++;
    end
    if (e.ifIdFlush) begin
      if (modelFlush  < 65535) modelFlush++;
      if (modelFlush4 < 15)    modelFlush4++;
    end
  endtask

  task automatic modelReset();
    modelPhase = 0; modelStall = 0; modelFlush = 0; modelStall4 = 0; modelFlush4 = 0;
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareFront(string tag);
    expT e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "/queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, "/pc_freeze"},    32'(pcFreeze),    32'(e.pcFreeze));
    checkOutput({tag, "/if_id_freeze"}, 32'(ifIdFreeze),  32'(e.ifIdFreeze));
    checkOutput({tag, "/id_ex_bubble"}, 32'(idExBubble),  32'(e.bubble));
    checkOutput({tag, "/if_id_flush"},  32'(ifIdFlush),   32'(e.ifIdFlush));
    checkOutput({tag, "/id_ex_flush"},  32'(idExFlush),   32'(e.idExFlush));
    checkOutput({tag, "/all_freeze"},   32'(allFreeze),   32'(e.allFreeze));
    checkOutput({tag, "/mem_done"},     32'(memDone),     32'(e.memDone));
    checkOutput({tag, "/stall_cnt"},    32'(stallCnt),    32'(e.stallCnt));
    checkOutput({tag, "/flush_cnt"},    32'(flushCnt),    32'(e.flushCnt));
    checkOutput({tag, "/w4_all_freeze"}, 32'(allFreeze4), 32'(e.allFreeze));
    checkOutput({tag, "/w4_mem_done"},  32'(memDone4),    32'(e.memDone));
    checkOutput({tag, "/w4_stall_cnt"}, 32'(stallCnt4),   32'(e.stallCnt4));
    checkOutput({tag, "/w4_flush_cnt"}, 32'(flushCnt4),   32'(e.flushCnt4));
  endtask

  task automatic driveInputs(stimT s);
    idSrc1 = s.src1;  idSrc2 = s.src2;   idTwoSrc = s.two;
    exWbEn = s.exWb;  exDest = s.exDest; exMemRd = s.exRd;
    memWbEn = s.memWb; memDest = s.memDest;
    branchTaken = s.branch; memReq = s.memReq;
  endtask

  // One clock cycle: drive after the edge, queue the prediction, compare mid-cycle.
  task automatic applyStimulus(string tag, stimT s);
    expT e;
    @(posedge clk);
    #1;
    driveInputs(s);
    e = predict(s);
    expQ.push_back(e);
    @(negedge clk);
    compareFront(tag);
    modelAdvance(s, e);
  endtask

  stimT idleS, hazExS, hazLoadS, hazMemS;

  initial begin
    idleS    = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    hazExS   = mk(3, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    hazLoadS = mk(3, 0, 0, 1, 3, 1, 0, 0, 0, 0);
    hazMemS  = mk(5, 9, 1, 0, 0, 0, 1, 9, 0, 0);

    // Reset held with request, branch and hazard all active: outputs must stay low.
    rst = 1'b1;
    driveInputs(mk(3, 0, 0, 1, 3, 1, 0, 0, 1, 1));
    #3;
    expQ.push_back(zeroExp());
    compareFront("reset_hold");
    @(negedge clk);
    expQ.push_back(zeroExp());
    compareFront("reset_hold_edge");
    driveInputs(idleS);
    #1 rst = 1'b0;
    modelReset();

    applyStimulus("idle", idleS);
    applyStimulus("idle_src2_unread", mk(7, 3, 0, 1, 3, 0, 0, 0, 0, 0));
    applyStimulus("haz_src2_read", mk(7, 3, 1, 1, 3, 0, 0, 0, 0, 0));
    applyStimulus("haz_ex_alu", hazExS);
    applyStimulus("haz_ex_load", hazLoadS);
    applyStimulus("haz_mem", hazMemS);
    applyStimulus("mem_wb_off", mk(5, 9, 1, 0, 0, 0, 0, 9, 0, 0));
    applyStimulus("ex_wb_off", mk(3, 0, 0, 0, 3, 1, 0, 0, 0, 0));
    applyStimulus("branch_haz_alu", mk(3, 0, 0, 1, 3, 0, 0, 0, 1, 0));
    applyStimulus("branch_haz_load", mk(3, 0, 0, 1, 3, 1, 0, 0, 1, 0));
    applyStimulus("idle_after_branch", idleS);

    // Two back-to-back accesses with request held and a hazard pending throughout.
    for (int i = 0; i < 2 * (MW + 1); i++) begin
      applyStimulus("mem_hold", mk(3, 0, 0, 1, 3, 1, 0, 0, 0, 1));
    end
    applyStimulus("mem_after", hazLoadS);
    applyStimulus("mem_idle", idleS);

    // Branch asserted through an access: flush only once released.
    applyStimulus("mem_branch_start", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < MW; i++) begin
      applyStimulus("mem_branch_wait", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    applyStimulus("mem_branch_idle", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
    applyStimulus("idle2", idleS);

    // Reset pulse in the third frozen cycle; the access must be abandoned.
    applyStimulus("rst_mem_f1", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus("rst_mem_f2", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    driveInputs(mk(3, 0, 0, 1, 3, 1, 0, 0, 1, 0));
    #1 rst = 1'b1;
    #1;
    expQ.push_back(zeroExp());
    compareFront("rst_async");
    @(negedge clk);
    expQ.push_back(zeroExp());
    compareFront("rst_async_hold");
    driveInputs(idleS);
    #1 rst = 1'b0;
    modelReset();
    for (int i = 0; i < MW + 2; i++) begin
      applyStimulus("post_rst_idle", idleS);
    end

    // Hazard held long enough to saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat_hazard", hazLoadS);
    end
    applyStimulus("sat_check", idleS);
    applyStimulus("sat_hold", hazLoadS);
    applyStimulus("sat_final", idleS);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_WAIT_CYCLES, default 5: total freeze cycles per memory access; legal range 1-15.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_src1, id_src2  in  4 each  source registers of the instruction in ID.
REQ-006 id_two_src  in  1  the ID instruction reads id_src2; id_src1 is always read.
REQ-007 ex_wb_en, ex_dest[3:0], ex_mem_rd  in  1/4/1  writeback enable, destination and load flag of the EX instruction.
REQ-008 mem_wb_en, mem_dest[3:0]  in  1/4  writeback enable and destination of the MEM instruction.
REQ-009 branch_taken  in  1  the EX instruction redirects the PC.
REQ-010 mem_req  in  1  the MEM instruction accesses data memory.
REQ-011 pc_freeze, if_id_freeze  out  1 each  hold the PC and the IF/ID register.
REQ-012 id_ex_bubble  out  1  load a NOP into ID/EX.
REQ-013 if_id_flush, id_ex_flush  out  1 each  clear IF/ID and ID/EX.
REQ-014 all_freeze  out  1  hold every pipeline register.
REQ-015 mem_done  out  1  memory access completes this cycle.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  event statistics.

Function
REQ-017 The RAW hazard is combinational: a source is live if it is id_src1, or id_src2 with id_two_src=1; the hazard uses the dependency rules in REQ-032/033.
REQ-018 The memory FSM has two states, IDLE and MEM_WAIT, and a 4-bit down-counter wcnt.
REQ-019 IDLE with mem_req=1: all_freeze=1; next state MEM_WAIT; wcnt loads MEM_WAIT_CYCLES-1.
REQ-020 MEM_WAIT with wcnt!=0: all_freeze=1; wcnt decrements.
REQ-021 MEM_WAIT with wcnt==0: all_freeze=0, mem_done=1; next state IDLE, regardless of mem_req.
REQ-022 Result: exactly MEM_WAIT_CYCLES frozen cycles followed by one release cycle; back-to-back accesses restart from IDLE.
REQ-023 Priority: all_freeze > branch flush > hazard stall.
REQ-024 While all_freeze=1: all other control outputs are 0; counters hold.
REQ-025 branch_taken=1 without all_freeze: if_id_flush=1 and id_ex_flush=1, same cycle; the hazard stall is suppressed.
REQ-026 Hazard without freeze or branch: pc_freeze=if_id_freeze=id_ex_bubble=1.
REQ-027 stall_cnt increments on each cycle that REQ-026 applies; flush_cnt increments on each cycle that REQ-025 applies.
REQ-028 Both counters saturate at all-ones; they never wrap.
REQ-029 mem_done is asserted only in MEM_WAIT with wcnt==0.

Reset
REQ-030 rst=1 forces state to IDLE, wcnt to 0 and both counters to 0, without waiting for a clock edge.
REQ-031 While rst=1, every control output is 0; an access in progress when rst asserts is abandoned and produces no mem_done.

Configuration
REQ-032 With macro PIPE_HAZARD_FORWARDING_EN defined, a hazard requires ex_wb_en=1, ex_mem_rd=1 and ex_dest equal to a live source (load-use only); MEM-stage dependencies do not stall.
REQ-033 Without the macro, a hazard is any live source equal to ex_dest with ex_wb_en=1, or equal to mem_dest with mem_wb_en=1.

Verification
REQ-034 Bench: mem_req=1 held from IDLE, MEM_WAIT_CYCLES=5 -> all_freeze high 5 cycles, then mem_done=1 for 1 cycle with all_freeze=0, then state IDLE.
REQ-035 Bench: ex_wb_en=1, ex_dest=3, ex_mem_rd=0, id_src1=3 -> stall without the macro; no stall with PIPE_HAZARD_FORWARDING_EN; with ex_mem_rd=1 -> stall in both builds.
REQ-036 Bench: branch_taken=1 together with the hazard of REQ-035 -> flushes=1, stall outputs=0, flush_cnt+1, stall_cnt unchanged.
REQ-037 Bench: branch_taken=1 during MEM_WAIT -> no flush until the release cycle; flush asserts in the release cycle.
REQ-038 Bench: rst pulse in the 3rd frozen cycle -> all outputs 0 immediately, no mem_done, counters 0.
REQ-039 Bench: CNT_W=4, hazard held 20 cycles -> stall_cnt reaches 15 and stays at 15.
